// File: rtl/ws2812_framebuf_if.sv
// Producer write port, commit handshake and driver read port of the
// ws2812 frame store, bundled so the producer/driver side uses one connection.
interface ws2812_framebuf_if #(
   parameter int ADDR_BITS = 3
);
   logic                 wr_en;
   logic                 wr_ready;
   logic [ADDR_BITS-1:0] wr_addr;
   logic [7:0]           wr_red;
   logic [7:0]           wr_green;
   logic [7:0]           wr_blue;
   logic                 commit;
   logic                 commit_pending;
   logic                 frame_done;
   logic [ADDR_BITS-1:0] address;
   logic                 new_address;
   logic [7:0]           red_out;
   logic [7:0]           green_out;
   logic [7:0]           blue_out;
   logic [7:0]           frame_count;

   modport master (
      output wr_en, wr_addr, wr_red, wr_green, wr_blue, commit, frame_done,
             address, new_address,
      input  wr_ready, commit_pending, red_out, green_out, blue_out, frame_count
   );

   modport slave (
      input  wr_en, wr_addr, wr_red, wr_green, wr_blue, commit, frame_done,
             address, new_address,
      output wr_ready, commit_pending, red_out, green_out, blue_out, frame_count
   );
endinterface

// File: rtl/ws2812_framebuf.sv
// Double-buffered RGB frame store feeding the ws2812c chain driver; bank swaps
// requested by commit are deferred to the driver's frame boundary.
module ws2812_framebuf #(
   parameter int NUM_LEDS  = 8,
   parameter int ADDR_BITS = 3
) (
   input logic               clk,
   input logic               reset,
   ws2812_framebuf_if.slave  bus
);
   localparam int unsigned DEPTH = 1 << ADDR_BITS;

   typedef enum logic {
      IDLE,
      PENDING
   } state_t;

   state_t      state;
   logic        bank_sel;
   // Banks are sized to the full address space so any address indexes cleanly;
   // entries at or above NUM_LEDS are never written and read back as zero.
   logic [23:0] bank [2][DEPTH];

   logic wr_in_range;
   logic rd_in_range;

   assign wr_in_range = int'(bus.wr_addr) < NUM_LEDS;
   assign rd_in_range = int'(bus.address) < NUM_LEDS;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            bank[0][i] <= '0;
            bank[1][i] <= '0;
         end
         bank_sel           <= 1'b0;
         state              <= IDLE;
         bus.wr_ready       <= 1'b1;
         bus.commit_pending <= 1'b0;
         bus.frame_count    <= '0;
         bus.red_out        <= '0;
         bus.green_out      <= '0;
         bus.blue_out       <= '0;
      end else begin
         if (bus.new_address) begin
            if (rd_in_range) begin
               {bus.red_out, bus.green_out, bus.blue_out} <= bank[bank_sel][bus.address];
            end else begin
               {bus.red_out, bus.green_out, bus.blue_out} <= '0;
            end
         end

         case (state)
            IDLE: begin
               if (bus.wr_en && wr_in_range) begin
                  bank[~bank_sel][bus.wr_addr] <= {bus.wr_red, bus.wr_green, bus.wr_blue};
               end
               if (bus.commit) begin
                  if (bus.frame_done) begin
                     bank_sel        <= ~bank_sel;
                     bus.frame_count <= bus.frame_count + 8'd1;
                  end else begin
                     state              <= PENDING;
                     bus.wr_ready       <= 1'b0;
                     bus.commit_pending <= 1'b1;
                  end
               end
            end
            PENDING: begin
               if (bus.frame_done) begin
                  bank_sel           <= ~bank_sel;
                  bus.frame_count    <= bus.frame_count + 8'd1;
                  state              <= IDLE;
                  bus.wr_ready       <= 1'b1;
                  bus.commit_pending <= 1'b0;
               end
            end
            default: begin
               state              <= IDLE;
               bus.wr_ready       <= 1'b1;
               bus.commit_pending <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ws2812_framebuf.sv
// Drives an 8-LED and a 7-LED frame store with identical stimulus and checks
// both against an array-based reference model every cycle.
module tb_ws2812_framebuf;
   logic clk = 1'b0;
   logic rst;

   logic        wr_en, commit, frame_done, new_address;
   logic [3:0]  wr_addr, address;
   logic [23:0] colour;

   int checks = 0;
   int errors = 0;

   ws2812_framebuf_if #(.ADDR_BITS(3)) if8 ();
   ws2812_framebuf_if #(.ADDR_BITS(4)) if7 ();

   assign if8.wr_en       = wr_en;
   assign if8.wr_addr     = wr_addr[2:0];
   assign if8.wr_red      = colour[23:16];
   assign if8.wr_green    = colour[15:8];
   assign if8.wr_blue     = colour[7:0];
   assign if8.commit      = commit;
   assign if8.frame_done  = frame_done;
   assign if8.address     = address[2:0];
   assign if8.new_address = new_address;

   assign if7.wr_en       = wr_en;
   assign if7.wr_addr     = wr_addr;
   assign if7.wr_red      = colour[23:16];
   assign if7.wr_green    = colour[15:8];
   assign if7.wr_blue     = colour[7:0];
   assign if7.commit      = commit;
   assign if7.frame_done  = frame_done;
   assign if7.address     = address;
   assign if7.new_address = new_address;

   ws2812_framebuf #(.NUM_LEDS(8), .ADDR_BITS(3)) dut8 (
      .clk   (clk),
      .reset (rst),
      .bus   (if8)
   );

   ws2812_framebuf #(.NUM_LEDS(7), .ADDR_BITS(4)) dut7 (
      .clk   (clk),
      .reset (rst),
      .bus   (if7)
   );

   always #5 clk = ~clk;

   // Reference model, index 0 = 8-LED instance, index 1 = 7-LED instance.
   logic [23:0] mbank [2][2][16];
   int          msel  [2];
   bit          mpend [2];
   logic [7:0]  mfc   [2];
   logic [23:0] mout  [2];

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         int n  = (i == 0) ? 8 : 7;
         int wa = (i == 0) ? int'(wr_addr[2:0]) : int'(wr_addr);
         int ra = (i == 0) ? int'(address[2:0]) : int'(address);
         if (rst) begin
            for (int b = 0; b < 2; b++)
               for (int e = 0; e < 16; e++) mbank[i][b][e] = 24'h0;
            msel[i]  = 0;
            mpend[i] = 0;
            mfc[i]   = 8'd0;
            mout[i]  = 24'h0;
         end else begin
            if (new_address) mout[i] = (ra < n) ? mbank[i][msel[i]][ra] : 24'h0;
            if (!mpend[i]) begin
               if (wr_en && wa < n) mbank[i][1 - msel[i]][wa] = colour;
               if (commit) begin
                  if (frame_done) begin
                     msel[i] = 1 - msel[i];
                     mfc[i]  = mfc[i] + 8'd1;
                  end else begin
                     mpend[i] = 1;
                  end
               end
            end else if (frame_done) begin
               msel[i]  = 1 - msel[i];
               mfc[i]   = mfc[i] + 8'd1;
               mpend[i] = 0;
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] rgb8();
      return {if8.red_out, if8.green_out, if8.blue_out};
   endfunction

   function automatic logic [23:0] rgb7();
      return {if7.red_out, if7.green_out, if7.blue_out};
   endfunction

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      check("rgb8",   32'(rgb8()),             32'(mout[0]));
      check("fc8",    32'(if8.frame_count),    32'(mfc[0]));
      check("rdy8",   32'(if8.wr_ready),       32'(!mpend[0]));
      check("pend8",  32'(if8.commit_pending), 32'(mpend[0]));
      check("rgb7",   32'(rgb7()),             32'(mout[1]));
      check("fc7",    32'(if7.frame_count),    32'(mfc[1]));
      check("rdy7",   32'(if7.wr_ready),       32'(!mpend[1]));
      check("pend7",  32'(if7.commit_pending), 32'(mpend[1]));
   endtask

   task automatic idle_inputs();
      wr_en = 0; commit = 0; frame_done = 0; new_address = 0;
   endtask

   task automatic read(input int a);
      new_address = 1; address = 4'(a);
      step();
      new_address = 0;
   endtask

   initial begin
      logic [7:0] fc_saved;
      rst = 1; idle_inputs(); wr_addr = 0; address = 0; colour = 0;
      step();
      rst = 0;
      check("reset_fc", 32'(if8.frame_count), 32'd0);
      check("reset_rdy", 32'(if8.wr_ready), 32'd1);

      for (int a = 0; a < 8; a++) begin
         read(a);
         check("reset_read", 32'(rgb8()), 32'd0);
      end

      // Write then read before commit: front bank still empty.
      wr_en = 1; wr_addr = 3; colour = 24'h123456;
      step();
      wr_en = 0;
      read(3);
      check("pre_commit_led3", 32'(rgb8()), 32'd0);

      commit = 1;
      step();
      commit = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         check("pending_window", 32'(if8.commit_pending), 32'd1);
      end
      frame_done = 1;
      step();
      frame_done = 0;
      check("pending_cleared", 32'(if8.commit_pending), 32'd0);
      read(3);
      check("led3_after_swap8", 32'(rgb8()), 32'h123456);
      check("led3_after_swap7", 32'(rgb7()), 32'h123456);
      check("fc_one", 32'(if8.frame_count), 32'd1);

      // Writes and a second commit while pending are ignored.
      commit = 1;
      step();
      wr_en = 1; wr_addr = 0; colour = 24'hFFFFFF;
      step();
      check("pending_rdy_low", 32'(if8.wr_ready), 32'd0);
      wr_en = 0; commit = 0;
      frame_done = 1;
      step();
      frame_done = 0;
      step();
      check("single_swap", 32'(if8.commit_pending), 32'd0);
      read(0);
      check("dropped_write", 32'(rgb8()), 32'd0);
      check("fc_two", 32'(if8.frame_count), 32'd2);

      // Same-cycle write + commit + frame_done.
      wr_en = 1; wr_addr = 7; colour = 24'h010203; commit = 1; frame_done = 1;
      step();
      idle_inputs();
      check("no_pending_same_cycle", 32'(if8.commit_pending), 32'd0);
      read(7);
      check("led7_8", 32'(rgb8()), 32'h010203);
      check("led7_7_oob", 32'(rgb7()), 32'd0);
      check("fc_three", 32'(if8.frame_count), 32'd3);

      // Out-of-range write on the 7-LED instance.
      wr_en = 1; wr_addr = 8; colour = 24'hAABBCC;
      step();
      wr_en = 0;
      read(7);
      check("oob_read7", 32'(rgb7()), 32'd0);

      fc_saved = if8.frame_count;
      commit = 1; frame_done = 1;
      for (int k = 0; k < 256; k++) step();
      idle_inputs();
      step();
      check("fc_wrap", 32'(if8.frame_count), 32'(fc_saved));

      // Reset while pending with nonzero banks.
      wr_en = 1; wr_addr = 2; colour = 24'h55AA33;
      step();
      wr_en = 0; commit = 1;
      step();
      commit = 0;
      check("pending_before_reset", 32'(if8.commit_pending), 32'd1);
      rst = 1; frame_done = 1;
      step();
      rst = 0; frame_done = 0;
      check("reset_pending", 32'(if8.commit_pending), 32'd0);
      check("reset_fc2", 32'(if8.frame_count), 32'd0);
      frame_done = 1;
      step();
      frame_done = 0;
      check("no_swap_after_reset", 32'(if8.frame_count), 32'd0);
      for (int a = 0; a < 8; a++) begin
         read(a);
         check("reset_read2", 32'(rgb8()), 32'd0);
      end

      for (int k = 0; k < 600; k++) begin
         rst         = ($urandom_range(0, 99) == 0);
         wr_en       = ($urandom_range(0, 1) == 1);
         wr_addr     = 4'($urandom_range(0, 15));
         colour      = 24'($urandom);
         commit      = ($urandom_range(0, 3) == 0);
         frame_done  = ($urandom_range(0, 5) == 0);
         new_address = ($urandom_range(0, 1) == 1);
         address     = 4'($urandom_range(0, 15));
         step();
      end
      rst = 0; idle_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
